// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared depth helper and {wr_ok, rd_ok} op-code encoding for the FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ============================================================================
// Module : fifo_ptr
// Brief  : Wrapping ADDR_WIDTH-bit pointer with increment enable, async reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ptr #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] ptr
);

    localparam logic [ADDR_WIDTH-1:0] c_one = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_ptr;

    // Wraps modulo 2**ADDR_WIDTH by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + c_one;
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module : fifo_ctrl
// Brief  : Pointer/flag controller for a show-ahead FIFO on a 2-port RAM.
//          Optional occupancy output enabled by defining FIFO_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    fifo_op_e              w_op;
    logic [ADDR_WIDTH-1:0] w_wptr;
    logic [ADDR_WIDTH-1:0] w_rptr;
    logic [ADDR_WIDTH-1:0] w_wptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rptr_nxt;
    logic                  r_full;
    logic                  r_empty;

    // A write into a full FIFO is only accepted when the head is freed this cycle.
    assign w_wr_ok    = wr & (~r_full | rd);
    assign w_rd_ok    = rd & ~r_empty;
    assign w_op       = fifo_op_e'({w_wr_ok, w_rd_ok});
    assign write_en   = w_wr_ok & ~reset;
    assign w_wptr_nxt = w_wptr + c_ptr_one;
    assign w_rptr_nxt = w_rptr + c_ptr_one;

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wr_ok),
        .ptr   (w_wptr)
    );

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_rd_ok),
        .ptr   (w_rptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            case (w_op)
                OP_WR: begin
                    r_empty <= 1'b0;
                    r_full  <= (w_wptr_nxt == w_rptr);
                end
                OP_RD: begin
                    r_full  <= 1'b0;
                    r_empty <= (w_rptr_nxt == w_wptr);
                end
                default: begin
                    r_full  <= r_full;
                    r_empty <= r_empty;
                end
            endcase
        end
    end

`ifdef FIFO_COUNT_EN
    localparam logic [ADDR_WIDTH:0] c_cnt_one = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case (w_op)
                OP_WR:   r_count <= r_count + c_cnt_one;
                OP_RD:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
`endif

    assign w_addr = w_wptr;
    assign r_addr = w_rptr;
    assign full   = r_full;
    assign empty  = r_empty;

endmodule

`default_nettype wire
